// File: rtl/ovl_win_unchange_sched.sv
// Round-robin scheduler sharing one ovl_win_unchange checker among NUM_REQ
// requesters. Each grant drives a start/hold/end window into the checker,
// watches chk_fire[0] through a short drain period, and then reports a
// pass/fail result tagged with the requester id.
//
// Optional feature: define OVL_WIN_SCHED_ERR_INJECT_EN to add the inject_err
// input. It flips test_expr[0] in the first window cycle, so a checker fire
// becomes the expected (passing) outcome.
module ovl_win_unchange_sched #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 4,
  parameter int LEN_W    = 4,
  parameter int FIRE_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
  input  logic                     inject_err,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     chk_enable,
  output logic                     start_event,
  output logic [WIDTH-1:0]         test_expr,
  output logic                     end_event,
  input  logic [2:0]               chk_fire,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic                     done_fail
);

  typedef enum logic [2:0] {IDLE, START, WINDOW, END, DRAIN, REPORT} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   data_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [2:0]         dcnt;
  logic               fire_seen;
  logic               inj_q;

  logic               sel_found;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W:0]      idx;
  logic [WIDTH-1:0]   sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               inj_in;
  logic               fail_now;
  logic               unused_fire;

  // Only the "assertion fired" bit of the checker matters here.
  assign unused_fire = &{1'b0, chk_fire[2:1]};

`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
  assign inj_in = inject_err;
`else
  assign inj_in = 1'b0;
`endif

  // An injected error is only real when a window cycle existed to carry it;
  // in that case a checker fire is the expected result.
  assign fail_now = (inj_q && (len_q != '0)) ? !fire_seen : fire_seen;

  // Pick the first requester at or above the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!sel_found && req[idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[ID_W-1:0];
      end
    end
  end

  // Extract the winning requester's data, length and grant bit.
  always_comb begin
    sel_data   = '0;
    sel_len    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_data      = req_data[i*WIDTH +: WIDTH];
        sel_len       = req_len[i*LEN_W +: LEN_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Transaction FSM with all checker-facing and result outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      data_q      <= '0;
      len_q       <= '0;
      cnt         <= '0;
      dcnt        <= '0;
      fire_seen   <= 1'b0;
      inj_q       <= 1'b0;
      gnt         <= '0;
      chk_enable  <= 1'b0;
      start_event <= 1'b0;
      end_event   <= 1'b0;
      test_expr   <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      done_fail   <= 1'b0;
    end else begin
      chk_enable <= enable;
      done       <= 1'b0;
      if ((state == START || state == WINDOW || state == END || state == DRAIN) && chk_fire[0])
        fire_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && sel_found) begin
            id_q        <= sel_id;
            data_q      <= sel_data;
            len_q       <= sel_len;
            inj_q       <= inj_in;
            gnt         <= sel_onehot;
            fire_seen   <= 1'b0;
            start_event <= 1'b1;
            test_expr   <= sel_data;
            state       <= START;
          end
        end
        START: begin
          start_event <= 1'b0;
          if (len_q != '0) begin
            cnt       <= len_q;
            test_expr <= data_q ^ {{(WIDTH-1){1'b0}}, inj_q};
            state     <= WINDOW;
          end else begin
            end_event <= 1'b1;
            state     <= END;
          end
        end
        WINDOW: begin
          test_expr <= data_q;
          if (cnt == LEN_W'(1)) begin
            end_event <= 1'b1;
            state     <= END;
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        END: begin
          end_event <= 1'b0;
          dcnt      <= 3'(FIRE_LAT);
          state     <= DRAIN;
        end
        DRAIN: begin
          if (dcnt == 3'd1) begin
            test_expr <= '0;
            state     <= REPORT;
          end else begin
            dcnt <= dcnt - 3'd1;
          end
        end
        REPORT: begin
          done      <= 1'b1;
          done_id   <= id_q;
          done_fail <= fail_now;
          gnt       <= '0;
          ptr       <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ovl_win_unchange_sched.sv
// Directed self-checking bench for ovl_win_unchange_sched (NUM_REQ=4,
// WIDTH=4, LEN_W=4, FIRE_LAT=1). Define OVL_WIN_SCHED_ERR_INJECT_EN to
// also exercise the error-injection option.
module tb_ovl_win_unchange_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [15:0] req_len;
  logic [2:0]  chk_fire;
  logic [3:0]  gnt;
  logic        chk_enable;
  logic        start_event;
  logic [3:0]  test_expr;
  logic        end_event;
  logic        done;
  logic [1:0]  done_id;
  logic        done_fail;
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
  logic        inject_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  ovl_win_unchange_sched #(
    .NUM_REQ(4), .WIDTH(4), .LEN_W(4), .FIRE_LAT(1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req(req), .req_data(req_data), .req_len(req_len),
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .gnt(gnt), .chk_enable(chk_enable), .start_event(start_event),
    .test_expr(test_expr), .end_event(end_event), .chk_fire(chk_fire),
    .done(done), .done_id(done_id), .done_fail(done_fail)
  );

  // Free-running clock, 10 ns period.
  always #5 clock = ~clock;

  // Hard stop in case the run ever stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected {gnt, start_event, end_event, test_expr, done} at cycle c after
  // the grant (c=0 is the START cycle), for a window of length len.
  function automatic logic [10:0] exp_vec(input int id, input int len,
                                          input logic [3:0] data, input int c);
    logic [3:0] g;
    logic [3:0] te;
    g  = (c <= len + 3) ? 4'(1 << id) : 4'd0;
    te = (c <= len + 2) ? data : 4'd0;
    return {g, 1'(c == 0), 1'(c == len + 1), te, 1'(c == len + 4)};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {gnt, start_event, end_event, test_expr, done};
  endfunction

  // Two-cycle synchronous reset leaving inputs idle and enable high.
  task automatic do_reset();
    reset = 1'b1; req = '0; chk_fire = '0; enable = 1'b1;
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // All outputs must be zero while reset is held, even with enable high.
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 4'b1111; req_data = 16'hFFFF;
    req_len = 16'h1111; chk_fire = 3'b111;
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    repeat (2) @(negedge clock);
    compared++;
    if ({obs_vec(), done_id, done_fail, chk_enable} !== 14'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {obs_vec(), done_id, done_fail, chk_enable});
    end
    reset = 1'b0; req = '0; chk_fire = '0;
  endtask

  // Single requester 0, data 8, length 3: done lands 7 cycles after gnt.
  task automatic test_single();
    logic [10:0] e;
    do_reset();
    req_data = 16'h0008; req_len = 16'h0003; req = 4'b0001;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clock);
      e = exp_vec(0, 3, 4'h8, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL single c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 0) begin
        compared++;
        if (chk_enable !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL single_chk_enable: got %b expected 1", chk_enable);
        end
      end
      if (c == 7) begin
        compared++;
        if ({done_id, done_fail} !== 3'b000) begin
          mismatched++;
          $display("[TB] FAIL single_result: got id=%0d fail=%b expected id=0 fail=0",
                   done_id, done_fail);
        end
        req = '0;
      end
    end
  endtask

  // All four requesting: grants rotate 0,1,2,3,0 with one IDLE cycle between.
  task automatic test_back_to_back();
    int lens [4] = '{3, 1, 0, 2};
    logic [10:0] e;
    int id;
    do_reset();
    req_data = 16'h4321; req_len = 16'h2013; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      for (int c = 0; c <= lens[id] + 4; c++) begin
        @(negedge clock);
        e = exp_vec(id, lens[id], 4'(id + 1), c);
        compared++;
        if (obs_vec() !== e) begin
          mismatched++;
          $display("[TB] FAIL b2b k=%0d c=%0d: got %b expected %b", k, c, obs_vec(), e);
        end
        if (c == lens[id] + 4) begin
          compared++;
          if ({done_id, done_fail} !== {2'(id), 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL b2b_result k=%0d: got id=%0d fail=%b expected id=%0d fail=0",
                     k, done_id, done_fail, id);
          end
          if (k == 4) req = '0;
        end
      end
    end
    @(negedge clock);
    compared++;
    if (gnt !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got gnt=%b expected 0000", gnt);
    end
  endtask

  // Zero-length window on requester 2; enable drop and input changes after
  // the grant must not disturb it, and no regrant follows while enable=0.
  task automatic test_len0();
    logic [10:0] e;
    do_reset();
    req_data = 16'h0500; req_len = 16'h0000; req = 4'b0100;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      e = exp_vec(2, 0, 4'h5, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL len0 c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 0) begin
        enable = 1'b0; req_data = 16'hFFFF; req_len = 16'hFFFF;
      end
      if (c == 1) begin
        compared++;
        if (chk_enable !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL len0_chk_enable: got %b expected 0", chk_enable);
        end
      end
      if (c == 4) begin
        compared++;
        if ({done_id, done_fail} !== 3'b100) begin
          mismatched++;
          $display("[TB] FAIL len0_result: got id=%0d fail=%b expected id=2 fail=0",
                   done_id, done_fail);
        end
      end
    end
    repeat (2) @(negedge clock);
    compared++;
    if ({gnt, start_event} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL len0_no_regrant: got gnt=%b start=%b expected 0000 0",
               gnt, start_event);
    end
    req = '0; enable = 1'b1;
  endtask

  // All-ones length on requester 3: 15 window cycles, done 19 after gnt.
  task automatic test_long();
    logic [10:0] e;
    do_reset();
    req_data = 16'hC000; req_len = 16'hF000; req = 4'b1000;
    for (int c = 0; c <= 19; c++) begin
      @(negedge clock);
      e = exp_vec(3, 15, 4'hC, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL long c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 19) begin
        compared++;
        if ({done_id, done_fail} !== 3'b110) begin
          mismatched++;
          $display("[TB] FAIL long_result: got id=%0d fail=%b expected id=3 fail=0",
                   done_id, done_fail);
        end
        req = '0;
      end
    end
  endtask

  // Fire in DRAIN fails the window; upper fire bits and an IDLE fire do not.
  task automatic test_fire();
    logic [10:0] e;
    do_reset();
    req_data = 16'h0030; req_len = 16'h0010; req = 4'b0010;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      e = exp_vec(1, 1, 4'h3, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL fire1 c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 1) chk_fire = 3'b110;
      if (c == 2) chk_fire = 3'b000;
      if (c == 3) chk_fire = 3'b001;
      if (c == 4) chk_fire = 3'b000;
      if (c == 5) begin
        compared++;
        if ({done_id, done_fail} !== 3'b011) begin
          mismatched++;
          $display("[TB] FAIL fire_drain_result: got id=%0d fail=%b expected id=1 fail=1",
                   done_id, done_fail);
        end
        req = 4'b0001; req_data = 16'h0006; req_len = 16'h0001; chk_fire = 3'b001;
      end
    end
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      e = exp_vec(0, 1, 4'h6, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL fire2 c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 0) chk_fire = 3'b000;
      if (c == 5) begin
        compared++;
        if ({done_id, done_fail} !== 3'b000) begin
          mismatched++;
          $display("[TB] FAIL fire_idle_result: got id=%0d fail=%b expected id=0 fail=0",
                   done_id, done_fail);
        end
        req = '0;
      end
    end
  endtask

  // Reset during requester 1's window aborts it and returns the pointer to 0.
  task automatic test_reset_mid();
    logic [10:0] e;
    do_reset();
    req_data = 16'h0090; req_len = 16'h0030; req = 4'b0010;
    for (int c = 0; c <= 1; c++) begin
      @(negedge clock);
      e = exp_vec(1, 3, 4'h9, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL resetmid c=%0d: got %b expected %b", c, obs_vec(), e);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if ({obs_vec(), done_fail, chk_enable} !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL resetmid_outputs: got %b expected all zero",
               {obs_vec(), done_fail, chk_enable});
    end
    reset = 1'b0; req = 4'b0011; req_data = 16'h0097; req_len = 16'h0032;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      e = exp_vec(0, 2, 4'h7, c);
      compared++;
      if (obs_vec() !== e) begin
        mismatched++;
        $display("[TB] FAIL resetmid_after c=%0d: got %b expected %b", c, obs_vec(), e);
      end
      if (c == 6) begin
        compared++;
        if ({done_id, done_fail} !== 3'b000) begin
          mismatched++;
          $display("[TB] FAIL resetmid_result: got id=%0d fail=%b expected id=0 fail=0",
                   done_id, done_fail);
        end
        req = '0;
      end
    end
  endtask

`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
  // Injection flips bit 0 in the first window cycle; a fire is a pass and
  // a missing fire is a fail.
  task automatic test_inject();
    logic [10:0] e;
    do_reset();
    inject_err = 1'b1; req_data = 16'h000A; req_len = 16'h0002; req = 4'b0001;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c <= 6; c++) begin
        @(negedge clock);
        e = exp_vec(0, 2, 4'hA, c);
        if (c == 1) e[4:1] = 4'hB;
        compared++;
        if (obs_vec() !== e) begin
          mismatched++;
          $display("[TB] FAIL inject p=%0d c=%0d: got %b expected %b", pass, c, obs_vec(), e);
        end
        if (c == 0) inject_err = (pass == 0);
        if (c == 2 && pass == 0) chk_fire = 3'b001;
        if (c == 3) chk_fire = 3'b000;
        if (c == 6) begin
          compared++;
          if (done_fail !== 1'(pass)) begin
            mismatched++;
            $display("[TB] FAIL inject_result p=%0d: got fail=%b expected %0d",
                     pass, done_fail, pass);
          end
          if (pass == 1) req = '0;
        end
      end
    end
    inject_err = 1'b0;
  endtask
`endif

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_len0();
    test_long();
    test_fire();
    test_reset_mid();
`ifdef OVL_WIN_SCHED_ERR_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
